timer_irq_unit: RTL and testbench

//  Memory-mapped 32-bit reload timer; direct upstream source of the CPU control unit's Interrupt input.

---
 rtl/timer_irq_unit_pkg.sv | 30 +++
 rtl/timer_irq_unit_if.sv | 20 ++
 rtl/timer_irq_unit_prescaler.sv | 28 ++
 rtl/timer_irq_unit.sv | 94 +++++++++
 tb/tb_timer_irq_unit.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/timer_irq_unit_pkg.sv
// rtl/timer_irq_unit_pkg.sv - shared timer register offsets, TCON bit indices and state decode
package timer_defs;

  localparam logic [1:0]  TH_OFS   = 2'd0;
  localparam logic [1:0]  TL_OFS   = 2'd1;
  localparam logic [1:0]  TCON_OFS = 2'd2;

  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_ST = 2;

  localparam logic [31:0] IRQ_VECTOR = 32'h8000_0004;

  typedef enum logic [1:0] {
    T_IDLE    = 2'd0,
    T_COUNT   = 2'd1,
    T_PENDING = 2'd2
  } timer_state_e;

  // The timer state is fully carried by TCON; this only names it.
  function automatic timer_state_e tcon_state(input logic [2:0] tcon);
    if (tcon[TCON_ST])
      return T_PENDING;
    else if (tcon[TCON_EN])
      return T_COUNT;
    else
      return T_IDLE;
  endfunction

endpackage

// File: rtl/timer_irq_unit_if.sv
// rtl/timer_irq_unit_if.sv - data-memory bus and interrupt bundle between CPU and timer
interface timer_irq_unit_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        MemWr;
  logic        MemRd;
  logic [31:0] rdata;
  logic        sel;
  logic        irq;

  modport master (
    output addr, wdata, MemWr, MemRd,
    input  rdata, sel, irq
  );

  modport slave (
    input  addr, wdata, MemWr, MemRd,
    output rdata, sel, irq
  );
endinterface

// File: rtl/timer_irq_unit_prescaler.sv
// rtl/timer_irq_unit_prescaler.sv - enable-gated divide-by-(PRESCALE+1) tick generator
module timer_prescaler #(
  parameter int PRESCALE = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int W = (PRESCALE < 1) ? 1 : $clog2(PRESCALE + 1);
  localparam logic [W-1:0] LAST = W'(PRESCALE);

  logic [W-1:0] count;

  assign tick = en && (count == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (en)
      count <= tick ? '0 : count + 1'b1;
  end

endmodule

// File: rtl/timer_irq_unit.sv
// rtl/timer_irq_unit.sv - memory-mapped 32-bit reload timer driving the CPU interrupt input
module timer_irq_unit
  import timer_defs::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int          PRESCALE  = 0
) (
  input  logic             clk,
  input  logic             reset,
  timer_irq_unit_if.slave  bus
);

  logic [31:0]  th;
  logic [31:0]  tl;
  logic         en;
  logic         ie;
  logic         st;
  logic [1:0]   word;
  logic         hit;
  logic         wr_th;
  logic         wr_tl;
  logic         wr_tcon;
  logic         tick;
  logic         overflow;
  logic         st_set;
  logic [31:0]  rd_word;
  logic         unused_lsb;
  timer_state_e state;

  assign word       = bus.addr[3:2];
  assign hit        = (bus.addr[31:4] == BASE_ADDR[31:4]) && (word != 2'd3);
  assign unused_lsb = ^bus.addr[1:0];
  assign bus.sel    = hit;

  assign wr_th   = bus.MemWr && hit && (word == TH_OFS);
  assign wr_tl   = bus.MemWr && hit && (word == TL_OFS);
  assign wr_tcon = bus.MemWr && hit && (word == TCON_OFS);

  timer_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .clr   (wr_tcon && !bus.wdata[TCON_EN]),
    .tick  (tick)
  );

  // A software write to TL pre-empts both the increment and the reload.
  assign overflow = tick && (tl == 32'hFFFF_FFFF);
  assign st_set   = overflow && ie && !wr_tl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th <= '0;
      tl <= '0;
      en <= 1'b0;
      ie <= 1'b0;
      st <= 1'b0;
    end else begin
      if (wr_th)
        th <= bus.wdata;
      if (wr_tl)
        tl <= bus.wdata;
      else if (overflow)
        tl <= th;
      else if (tick)
        tl <= tl + 32'd1;
      if (wr_tcon) begin
        en <= bus.wdata[TCON_EN];
        ie <= bus.wdata[TCON_IE];
        st <= bus.wdata[TCON_ST] || st_set;
      end else if (st_set) begin
        st <= 1'b1;
      end
    end
  end

  always_comb begin
    rd_word = '0;
    case (word)
      TH_OFS:   rd_word = th;
      TL_OFS:   rd_word = tl;
      TCON_OFS: rd_word = {29'd0, st, ie, en};
      default:  rd_word = '0;
    endcase
  end

  assign bus.rdata = (bus.MemRd && hit) ? rd_word : 32'd0;

  assign state   = tcon_state({st, ie, en});
  assign bus.irq = ie && (state == T_PENDING);

endmodule

// File: tb/tb_timer_irq_unit.sv
// tb/tb_timer_irq_unit.sv - two timer instances (PRESCALE 0 and 3) against a behavioural model
module tb_timer_irq_unit;
  import timer_defs::*;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam logic [31:0] MAX  = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        MemWr = 1'b0;
  logic        MemRd = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  timer_irq_unit_if bus0 ();
  timer_irq_unit_if bus3 ();

  assign bus0.addr = addr;  assign bus0.wdata = wdata;
  assign bus0.MemWr = MemWr; assign bus0.MemRd = MemRd;
  assign bus3.addr = addr;  assign bus3.wdata = wdata;
  assign bus3.MemWr = MemWr; assign bus3.MemRd = MemRd;

  timer_irq_unit #(.BASE_ADDR(BASE), .PRESCALE(0)) u_dut0 (.clk(clk), .reset(reset), .bus(bus0));
  timer_irq_unit #(.BASE_ADDR(BASE), .PRESCALE(3)) u_dut3 (.clk(clk), .reset(reset), .bus(bus3));

  // Model state: index 0 -> PRESCALE 0, index 1 -> PRESCALE 3
  logic [31:0] m_th[2];
  logic [31:0] m_tl[2];
  bit          m_en[2];
  bit          m_ie[2];
  bit          m_st[2];
  int          m_ph[2];

  function automatic int pre_of(input int i);
    return (i == 0) ? 0 : 3;
  endfunction

  function automatic int word_of(input logic [31:0] a);
    if ((a & 32'hFFFF_FFF0) == BASE && a[3:2] != 2'd3)
      return int'(a[3:2]);
    return -1;
  endfunction

  function automatic logic [31:0] m_reg(input int i, input int w);
    case (w)
      0: return m_th[i];
      1: return m_tl[i];
      2: return {29'd0, m_st[i], m_ie[i], m_en[i]};
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    int w;
    bit wtl, wtcon, tk, ovf;
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        m_th[i] = '0; m_tl[i] = '0; m_en[i] = 0; m_ie[i] = 0; m_st[i] = 0; m_ph[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        w     = word_of(addr);
        wtl   = MemWr && (w == 1);
        wtcon = MemWr && (w == 2);
        tk    = 0;
        if (m_en[i]) begin
          m_ph[i] = (m_ph[i] + 1) % (pre_of(i) + 1);
          tk = (m_ph[i] == 0);
        end
        if (wtcon && !wdata[0])
          m_ph[i] = 0;
        ovf = tk && (m_tl[i] == MAX) && !wtl;
        if (wtl)
          m_tl[i] = wdata;
        else if (ovf)
          m_tl[i] = m_th[i];
        else if (tk)
          m_tl[i] = m_tl[i] + 32'd1;
        if (MemWr && w == 0)
          m_th[i] = wdata;
        if (wtcon) begin
          m_st[i] = wdata[2] || (ovf && m_ie[i]);
          m_en[i] = wdata[0];
          m_ie[i] = wdata[1];
        end else if (ovf && m_ie[i]) begin
          m_st[i] = 1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_rdata(input int i);
    int w;
    w = word_of(addr);
    return (MemRd && w >= 0) ? m_reg(i, w) : 32'd0;
  endfunction

  always @(negedge clk) begin
    chk("sel_p0",   {31'd0, bus0.sel}, {31'd0, word_of(addr) >= 0});
    chk("sel_p3",   {31'd0, bus3.sel}, {31'd0, word_of(addr) >= 0});
    chk("irq_p0",   {31'd0, bus0.irq}, {31'd0, m_ie[0] && m_st[0]});
    chk("irq_p3",   {31'd0, bus3.irq}, {31'd0, m_ie[1] && m_st[1]});
    chk("rdata_p0", bus0.rdata, exp_rdata(0));
    chk("rdata_p3", bus3.rdata, exp_rdata(1));
  end

  task automatic step(input bit we, input bit re, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    #2;
    MemWr = we; MemRd = re; addr = a; wdata = d;
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    step(1, 0, a, d);
  endtask

  task automatic rd(input logic [31:0] a);
    step(0, 1, a, 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    reset = 1; MemWr = 0; MemRd = 0;
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 0;
  endtask

  initial begin
    logic [31:0] a, d;
    int r;
    #1 reset = 1;
    @(posedge clk);
    @(posedge clk);
    #2 reset = 0;
    rd(BASE + 8);
    chk("reset_tcon", bus0.rdata, 32'd0);

    // Overflow and reload period, PRESCALE 0
    wr(BASE, 32'hFFFF_FFFC);
    wr(BASE + 4, 32'hFFFF_FFFE);
    wr(BASE + 8, 32'd3);
    rd(BASE + 4); chk("ovf_tl0", bus0.rdata, 32'hFFFF_FFFE); chk("ovf_irq0", {31'd0, bus0.irq}, 32'd0);
    rd(BASE + 4); chk("ovf_tl1", bus0.rdata, 32'hFFFF_FFFF);
    rd(BASE + 4); chk("ovf_tl2", bus0.rdata, 32'hFFFF_FFFC); chk("ovf_irq2", {31'd0, bus0.irq}, 32'd1);
    rd(BASE + 4); rd(BASE + 4);
    rd(BASE + 4); chk("period_tl_ff", bus0.rdata, 32'hFFFF_FFFF);
    rd(BASE + 4); chk("period_tl", bus0.rdata, 32'hFFFF_FFFC); chk("period_irq", {31'd0, bus0.irq}, 32'd1);

    // Software clear, counting continues
    wr(BASE + 8, 32'd3);
    rd(BASE + 4); chk("clr_tl", bus0.rdata, 32'hFFFF_FFFE); chk("clr_irq", {31'd0, bus0.irq}, 32'd0);

    // TCON write on the overflow edge: set wins
    wr(BASE + 8, 32'd3);
    rd(BASE + 8); chk("col_tcon", bus0.rdata, 32'd7); chk("col_irq", {31'd0, bus0.irq}, 32'd1);

    // TL write on the overflow edge: written value wins, ST untouched
    wr(BASE + 8, 32'd3);
    rd(BASE + 4);
    wr(BASE + 4, 32'd7);
    rd(BASE + 4); chk("coltl_tl", bus0.rdata, 32'd7); chk("coltl_irq", {31'd0, bus0.irq}, 32'd0);
    rd(BASE + 8); chk("coltl_tcon", bus0.rdata, 32'd3);

    // Decode holes and ignored low address bits
    rd(BASE + 12); chk("hole_sel", {31'd0, bus0.sel}, 32'd0); chk("hole_rd", bus0.rdata, 32'd0);
    rd(32'h4000_0010); chk("next_sel", {31'd0, bus0.sel}, 32'd0); chk("next_rd", bus0.rdata, 32'd0);
    wr(BASE + 8, 32'd0);
    wr(BASE, 32'd5);
    wr(BASE + 4, 32'hFFFF_FFFE);
    wr(BASE + 9, 32'd1);
    rd(BASE + 4); chk("dec_tl0", bus0.rdata, 32'hFFFF_FFFE);
    rd(BASE + 4);
    rd(BASE + 4); chk("dec_reload", bus0.rdata, 32'd5); chk("dec_irq", {31'd0, bus0.irq}, 32'd0);
    rd(BASE + 8); chk("dec_tcon", bus0.rdata, 32'd1);

    // Prescaler, PRESCALE 3
    do_reset();
    wr(BASE + 8, 32'd1);
    for (int j = 0; j <= 12; j++) begin
      rd(BASE + 4);
      if (j == 3)  chk("pre_tl_j3", bus3.rdata, 32'd0);
      if (j == 4)  chk("pre_tl_j4", bus3.rdata, 32'd1);
      if (j == 12) chk("pre_tl_j12", bus3.rdata, 32'd3);
    end
    wr(BASE + 8, 32'd0);
    for (int j = 0; j < 5; j++) rd(BASE + 4);
    wr(BASE + 8, 32'd1);
    for (int j = 1; j <= 5; j++) begin
      rd(BASE + 4);
      if (j == 4) chk("pre_hold", bus3.rdata, 32'd3);
      if (j == 5) chk("pre_resume", bus3.rdata, 32'd4);
    end

    // Asynchronous reset while pending
    wr(BASE + 4, 32'd5);
    wr(BASE + 8, 32'd7);
    rd(BASE + 8); chk("pre_rst_irq", {31'd0, bus0.irq}, 32'd1);
    @(posedge clk);
    #2;
    reset = 1; MemWr = 0; MemRd = 1; addr = BASE + 4;
    #1;
    chk("rst_irq0", {31'd0, bus0.irq}, 32'd0);
    chk("rst_irq3", {31'd0, bus3.irq}, 32'd0);
    chk("rst_tl", bus0.rdata, 32'd0);
    @(posedge clk);
    #2 reset = 0;

    // Randomized traffic
    for (int k = 0; k < 800; k++) begin
      r = $urandom_range(0, 9);
      if (r == 0)
        a = $urandom;
      else if (r == 1)
        a = 32'h4000_0010;
      else
        a = BASE + $urandom_range(0, 15);
      case (a[3:2])
        2'd1:    d = ($urandom_range(0, 1) == 1) ? MAX - $urandom_range(0, 6) : $urandom;
        2'd2:    d = ($urandom_range(0, 3) == 0) ? $urandom : {29'd0, 3'($urandom_range(0, 7))};
        default: d = ($urandom_range(0, 1) == 1) ? MAX - $urandom_range(0, 12) : $urandom;
      endcase
      if ($urandom_range(0, 299) == 0)
        do_reset();
      else
        step($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, a, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
